// File: rtl/pst_stim_pkg.sv
// Shared types and defaults for the pst stimulus sequencer.
// Holds the gamma window length default, the current/repeat field widths,
// the packed step layout {rpt, c3, c2, c1, c0} and the FSM state encoding.
package pst_stim_pkg;

  localparam int GAMMA_LEN_DEF = 256;
  localparam int CUR_W         = 8;
  localparam int RPT_W_DEF     = 8;

  // One program step as stored in the step RAM; c0 sits in the LSBs.
  typedef struct packed {
    logic [RPT_W_DEF-1:0] rpt;
    logic [CUR_W-1:0]     c3;
    logic [CUR_W-1:0]     c2;
    logic [CUR_W-1:0]     c1;
    logic [CUR_W-1:0]     c0;
  } step_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pst_stim_mem.sv
// Step program RAM: DEPTH entries of DW bits, one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset.
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module pst_stim_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 40
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pst_stim_sequencer.sv
// Stimulus sequencer: plays a programmed list of steps (4 currents + repeat
// count), one gamma window of GAMMA_LEN clocks per repeat, into cur0..cur3.
// Ports: clk_i/rst_i (sync, active-high); prog_we_i/prog_addr_i/prog_data_i
//  step writes (rejected with prog_err_o while busy); n_steps_i, loop_en_i,
//  start_i, stop_i control; cur0_o..cur3_o, step_idx_o, gamma_tick_o, busy_o,
//  done_o status. Currents appear one clock after the start/step change.
module pst_stim_sequencer
  import pst_stim_pkg::*;
#(
  parameter int GAMMA_LEN = GAMMA_LEN_DEF,
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int RPT_W     = RPT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   prog_we_i,
  input  logic [AW-1:0]          prog_addr_i,
  input  logic [4*CUR_W+RPT_W-1:0] prog_data_i,
  output logic                   prog_err_o,
  input  logic [AW:0]            n_steps_i,
  input  logic                   loop_en_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic [CUR_W-1:0]       cur0_o,
  output logic [CUR_W-1:0]       cur1_o,
  output logic [CUR_W-1:0]       cur2_o,
  output logic [CUR_W-1:0]       cur3_o,
  output logic [AW-1:0]          step_idx_o,
  output logic                   gamma_tick_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int             GW        = $clog2(GAMMA_LEN);
  localparam int             DW        = 4*CUR_W + RPT_W;
  localparam logic [GW-1:0]  GCNT_LAST = GW'(GAMMA_LEN - 1);
  localparam logic [AW:0]    DEPTH_N   = (AW+1)'(DEPTH);

  state_e             state_q, state_d;
  logic [AW-1:0]      step_q, step_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [RPT_W-1:0]   rcnt_q, rcnt_d;
  logic [RPT_W-1:0]   rpt_q, rpt_d;
  logic [AW:0]        nsteps_q, nsteps_d;
  logic [CUR_W-1:0]   cur0_q, cur0_d, cur1_q, cur1_d;
  logic [CUR_W-1:0]   cur2_q, cur2_d, cur3_q, cur3_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               win_end, step_end, last_step;
  logic [RPT_W-1:0]   rcnt_inc, rpt_eff;
  logic               load, go_idle;

  // Writes only land while idle so the running program is never disturbed.
  pst_stim_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (prog_we_i && (state_q == S_IDLE)),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign win_end   = (gcnt_q == GCNT_LAST);
  assign rcnt_inc  = rcnt_q + RPT_W'(1);
  // A zero repeat field still plays one window.
  assign rpt_eff   = (rpt_q == '0) ? RPT_W'(1) : rpt_q;
  assign step_end  = win_end && (rcnt_inc == rpt_eff);
  assign last_step = ({1'b0, step_q} == (nsteps_q - (AW+1)'(1)));
  // The read port always presents the step that would be loaded next.
  assign rd_addr   = ((state_q == S_RUN) && !last_step) ? (step_q + AW'(1)) : '0;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gcnt_d   = gcnt_q;
    rcnt_d   = rcnt_q;
    rpt_d    = rpt_q;
    nsteps_d = nsteps_q;
    cur0_d   = cur0_q;
    cur1_d   = cur1_q;
    cur2_d   = cur2_q;
    cur3_d   = cur3_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    go_idle  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (n_steps_i == '0) begin
            done_d = 1'b1;
          end else begin
            nsteps_d = (n_steps_i > DEPTH_N) ? DEPTH_N : n_steps_i;
            step_d   = '0;
            gcnt_d   = '0;
            rcnt_d   = '0;
            load     = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        err_d = prog_we_i;
        if (stop_i) begin
          go_idle = 1'b1;
        end else begin
          gcnt_d = win_end ? '0 : (gcnt_q + GW'(1));
          if (step_end) begin
            rcnt_d = '0;
            if (!last_step) begin
              step_d = step_q + AW'(1);
              load   = 1'b1;
            end else if (loop_en_i) begin
              step_d = '0;
              load   = 1'b1;
            end else begin
              go_idle = 1'b1;
              done_d  = 1'b1;
            end
          end else if (win_end) begin
            rcnt_d = rcnt_inc;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (load) begin
      cur0_d = rd_data[0*CUR_W +: CUR_W];
      cur1_d = rd_data[1*CUR_W +: CUR_W];
      cur2_d = rd_data[2*CUR_W +: CUR_W];
      cur3_d = rd_data[3*CUR_W +: CUR_W];
      rpt_d  = rd_data[4*CUR_W +: RPT_W];
    end

    if (go_idle) begin
      state_d = S_IDLE;
      step_d  = '0;
      gcnt_d  = '0;
      rcnt_d  = '0;
      cur0_d  = '0;
      cur1_d  = '0;
      cur2_d  = '0;
      cur3_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      gcnt_q   <= '0;
      rcnt_q   <= '0;
      rpt_q    <= '0;
      nsteps_q <= '0;
      cur0_q   <= '0;
      cur1_q   <= '0;
      cur2_q   <= '0;
      cur3_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      gcnt_q   <= gcnt_d;
      rcnt_q   <= rcnt_d;
      rpt_q    <= rpt_d;
      nsteps_q <= nsteps_d;
      cur0_q   <= cur0_d;
      cur1_q   <= cur1_d;
      cur2_q   <= cur2_d;
      cur3_q   <= cur3_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cur0_o       = cur0_q;
  assign cur1_o       = cur1_q;
  assign cur2_o       = cur2_q;
  assign cur3_o       = cur3_q;
  assign step_idx_o   = step_q;
  assign gamma_tick_o = (state_q == S_RUN) && win_end;
  assign busy_o       = (state_q == S_RUN);
  assign done_o       = done_q;
  assign prog_err_o   = err_q;

endmodule

// File: tb/tb_pst_stim_sequencer.sv
// Directed bench for pst_stim_sequencer: reset, single step timing, A/B
// alternation with looping, stop/write protection, rpt=0, n_steps=0/20 and
// synchronous reset while running.
module tb_pst_stim_sequencer;
  import pst_stim_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [39:0] prog_data;
  logic        prog_err;
  logic [4:0]  n_steps;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [7:0]  cur0, cur1, cur2, cur3;
  logic [3:0]  step_idx;
  logic        gamma_tick;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pst_stim_sequencer #(
    .GAMMA_LEN (256),
    .DEPTH     (16),
    .AW        (4),
    .RPT_W     (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .prog_we_i    (prog_we),
    .prog_addr_i  (prog_addr),
    .prog_data_i  (prog_data),
    .prog_err_o   (prog_err),
    .n_steps_i    (n_steps),
    .loop_en_i    (loop_en),
    .start_i      (start),
    .stop_i       (stop),
    .cur0_o       (cur0),
    .cur1_o       (cur1),
    .cur2_o       (cur2),
    .cur3_o       (cur3),
    .step_idx_o   (step_idx),
    .gamma_tick_o (gamma_tick),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Writes one step; c0..c3 land on cur0..cur3.
  task automatic prog(input int addr, input int rpt, input int c0, input int c1,
                      input int c2, input int c3);
    step_t s;
    s.rpt = 8'(rpt);
    s.c0  = 8'(c0);
    s.c1  = 8'(c1);
    s.c2  = 8'(c2);
    s.c3  = 8'(c3);
    prog_we   = 1'b1;
    prog_addr = 4'(addr);
    prog_data = s;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic kick(input int n, input logic lp);
    n_steps = 5'(n);
    loop_en = lp;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    int first_tick, second_tick, ntick, first_done, bad, dn, expv;

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    n_steps = 5'd1; loop_en = 1'b0; start = 1'b1; stop = 1'b0;

    // 1: reset with start held high
    steps(3);
    check("rst_busy", busy, 0);
    check("rst_cur0", cur0, 0);
    check("rst_tick", gamma_tick, 0);
    check("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("post_rst_busy", busy, 0);

    // 2: single step, rpt=2, two windows
    prog(0, 2, 200, 180, 5, 8);
    kick(1, 1'b0);
    check("s_cur0", cur0, 200);
    check("s_cur1", cur1, 180);
    check("s_cur2", cur2, 5);
    check("s_cur3", cur3, 8);
    check("s_busy", busy, 1);
    first_tick = 0; second_tick = 0; ntick = 0; first_done = 0;
    for (int k = 2; k <= 514; k++) begin
      step();
      if (gamma_tick) begin
        ntick++;
        if (ntick == 1) first_tick = k;
        if (ntick == 2) second_tick = k;
      end
      if (done && first_done == 0) first_done = k;
      if (k == 513) begin
        check("s_end_busy", busy, 0);
        check("s_end_cur0", cur0, 0);
      end
    end
    check("s_tick1", first_tick, 256);
    check("s_tick2", second_tick, 512);
    check("s_ntick", ntick, 2);
    check("s_done_at", first_done, 513);
    check("s_done_pulse", done, 0);

    // 3: A/B alternation with loop, 32 windows
    prog(0, 1, 200, 180, 5, 8);
    prog(1, 1, 5, 8, 200, 180);
    kick(2, 1'b1);
    bad = 0; dn = 0;
    for (int k = 1; k <= 8192; k++) begin
      expv = (((k - 1) / 256) % 2 == 0) ? 200 : 5;
      if (cur0 !== 8'(expv)) bad++;
      if (done) dn++;
      step();
    end
    check("alt_cur_bad", bad, 0);
    check("alt_done_cnt", dn, 0);
    check("alt_wrap_cur0", cur0, 200);
    check("alt_busy", busy, 1);

    // 4: stop mid-window of step 1, write attempt while running
    steps(384);
    check("stop_pre_idx", step_idx, 1);
    check("stop_pre_cur2", cur2, 200);
    stop = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 40'hFF_1111_1111;
    step();
    stop = 1'b0; prog_we = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_cur0", cur0, 0);
    check("stop_done", done, 0);
    check("prog_err_pulse", prog_err, 1);
    step();
    check("prog_err_clear", prog_err, 0);
    check("stop_idle_done", done, 0);
    kick(1, 1'b0);
    check("rerun_cur0", cur0, 200);
    check("rerun_cur3", cur3, 8);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // 5a: rpt=0 plays one window
    prog(0, 0, 11, 22, 33, 44);
    kick(1, 1'b0);
    check("r0_cur1", cur1, 22);
    steps(255);
    check("r0_tick", gamma_tick, 1);
    check("r0_nodone", done, 0);
    step();
    check("r0_done", done, 1);
    check("r0_busy", busy, 0);

    // 5b: n_steps=0
    kick(0, 1'b0);
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    step();
    check("n0_done_pulse", done, 0);

    // 5c: n_steps=20 clamps to 16
    for (int i = 0; i < 16; i++) prog(i, 1, i + 1, 0, 0, 100 - i);
    kick(20, 1'b0);
    for (int s = 0; s < 16; s++) begin
      check("clamp_cur0", cur0, s + 1);
      check("clamp_idx", step_idx, s);
      steps(256);
    end
    check("clamp_done", done, 1);
    check("clamp_busy", busy, 0);

    // 5d: synchronous reset mid-run
    kick(2, 1'b1);
    steps(300);
    check("mr_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_busy", busy, 0);
    check("mr_cur0", cur0, 0);
    check("mr_idx", step_idx, 0);
    check("mr_tick", gamma_tick, 0);
    check("mr_done", done, 0);
    step();
    check("mr_stay_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
